bcd_timer_ctrl: RTL and testbench
=================================

# bcd_timer_ctrl

Controller that sequences a cascade of DIGITS decade (0-9) counter cells into a multi-digit BCD event timer. It accepts start/stop/clear commands and a tick enable, compares the count against a BCD target, and flags completion and wrap-around. It sits between the control/register interface and the decade counter datapath, owning all enable and clear sequencing for the cascade.

## Interface
Parameters:
- DIGITS, 4, number of cascaded BCD digits (1-8); count width is 4*DIGITS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_start  in  1  single-cycle start/resume request.
- cmd_stop  in  1  single-cycle pause request.
- cmd_clear  in  1  single-cycle clear request.
- tick  in  1  count-enable pulse, one increment per high cycle while running.
- reload  in  1  1 = restart automatically from 0 after a target match.
- target  in  4*DIGITS  BCD terminal value, digit 0 in bits [3:0].
- count  out  4*DIGITS  current BCD count, registered.
- running  out  1  high while state is RUN.
- done  out  1  one-cycle pulse on target match.
- wrap  out  1  one-cycle pulse when the count rolls from all-9s to 0.
- target_err  out  1  registered; high while any target digit is greater than 9.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Command priority within one cycle: clear > stop > start. Commands are ignored where no transition is listed.
- IDLE: start -> RUN. Clear -> count = 0, stay in IDLE.
- RUN:
  - clear -> count = 0, IDLE.
  - stop -> PAUSE.
  - otherwise, tick -> BCD increment.
- PAUSE: start -> RUN with count held. Clear -> count = 0, IDLE.
- DONE:
  - reload = 1 -> next cycle count = 0, RUN.
  - reload = 0 -> hold count.
    - start -> count = 0, RUN.
    - clear -> count = 0, IDLE.
- BCD increment: digit 0 always steps. Digit k steps only when all lower digits equal 9. Any digit at 9 that steps becomes 0. Digit values are never 10-15.
- A tick in a cycle with clear or stop is discarded. A tick outside RUN is discarded.
- Match check: the next count value is compared with target. On equality the state goes to DONE and done pulses.
- While target_err = 1, no match occurs and counting continues.
- All-9s + tick -> count = 0 and wrap pulses.
  - If target = 0, the same event is also a match: done and wrap pulse in the same cycle.
- A change to target takes effect for the next tick.
- A target lower than the current count matches only after a wrap.

## Timing
- Reset values: count = 0, state IDLE, running = 0, done = 0, wrap = 0, target_err = 0.
- tick sampled at edge N:
  - count updated after edge N.
  - done, wrap and the state change are visible in the same cycle as the new count.
- Commands take effect one cycle after sampling. running reflects the new state in that cycle.
- done and wrap are high for exactly one cycle.
- With reload = 1, DONE lasts exactly one cycle. A tick during that DONE cycle is discarded.
- Reset asserted mid-count returns all outputs to reset values immediately (asynchronous). The first active edge after deassertion is a normal IDLE cycle.

## Structure
- Package bcd_timer_pkg:
  - state enum: IDLE, RUN, PAUSE, DONE.
  - BCD_MAX = 4'd9.
  - function is_bcd_valid(digit).
- Sub-module bcd_digit_cell, one instance per digit via generate. Its behaviour:
  - ports: clk, rst, clr, inc, carry_in, value[3:0], carry_out.
  - steps when inc is high and carry_in is high.
  - carry_out = carry_in and value == 9.
- Top level contains the FSM, the command priority logic, the next-count match compare and the pulse registers.

## Test plan
- Reset, start, 5 ticks, DIGITS = 4, target = 0x0005 -> count 0x0005, done for 1 cycle, state DONE, running = 0.
- count 0x0099 with target 0x0150, 1 tick -> count 0x0100, no done. Continue to 0x0150 -> done.
- count 0x9999 with target = 0x0000, 1 tick -> count 0x0000, done and wrap both high in the same cycle.
- RUN with stop and tick in the same cycle -> count unchanged, state PAUSE. Start -> count resumes from the held value.
- clear, stop, start and tick together in RUN -> count 0, state IDLE, no done.
- target 0x00A3 -> target_err = 1, no done through a full wrap.
- reload = 1, target 0x0002 -> done pulses every 3 ticks, counting from 0.
- Reset asserted mid-count -> all outputs return to reset values.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD event timer controller and its digit cells.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd_valid(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade (0-9) counter digit; steps on inc while carry_in is high, rolls 9 -> 0.
module bcd_digit_cell
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       carry_in,
  output logic [3:0] value,
  output logic       carry_out
);

  logic [3:0] value_q;
  logic [3:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && carry_in) begin
      value_d = (value_q == BCD_MAX) ? 4'd0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value     = value_q;
  assign carry_out = carry_in && (value_q == BCD_MAX);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// BCD event timer controller: command FSM, cascade sequencing, next-count target match
// and one-cycle done/wrap pulses over a chain of bcd_digit_cell instances.
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_start,
  input  logic                  cmd_stop,
  input  logic                  cmd_clear,
  input  logic                  tick,
  input  logic                  reload,
  input  logic [4*DIGITS-1:0]   target,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  wrap,
  output logic                  target_err
);

  state_e state_q, state_d;

  logic                clr_cnt;
  logic                step;
  logic                done_q, done_d;
  logic                wrap_q, wrap_d;
  logic                terr_q, terr_d;
  logic                tgt_valid;
  logic                match;
  logic [DIGITS-1:0]   cin;
  logic [DIGITS-1:0]   cout;
  logic [4*DIGITS-1:0] next_count;

  // Carry into digit k is the AND of "digit j is 9" over all lower digits.
  always_comb begin : carry_gen
    logic all9;
    all9 = 1'b1;
    cin  = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      cin[k] = all9;
      all9   = all9 && (count[4*k +: 4] == BCD_MAX);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr_cnt),
      .inc       (step),
      .carry_in  (cin[g]),
      .value     (count[4*g +: 4]),
      .carry_out (cout[g])
    );
  end

  // Value the cascade would hold after one increment; compared against target.
  always_comb begin
    next_count = count;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (cout[k]) begin
        next_count[4*k +: 4] = '0;
      end else if (cin[k]) begin
        next_count[4*k +: 4] = count[4*k +: 4] + 4'd1;
      end
    end
  end

  always_comb begin
    tgt_valid = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      tgt_valid = tgt_valid && is_bcd_valid(target[4*k +: 4]);
    end
  end

  assign match  = tgt_valid && (next_count == target);
  assign terr_d = !tgt_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_cnt = 1'b0;
    step    = 1'b0;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_clear) begin
          clr_cnt = 1'b1;
        end else if (cmd_start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cmd_clear) begin
          clr_cnt = 1'b1;
          state_d = IDLE;
        end else if (cmd_stop) begin
          state_d = PAUSE;
        end else if (tick) begin
          step   = 1'b1;
          wrap_d = cout[DIGITS-1];
          if (match) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      PAUSE: begin
        if (cmd_clear) begin
          clr_cnt = 1'b1;
          state_d = IDLE;
        end else if (cmd_start) begin
          state_d = RUN;
        end
      end
      DONE: begin
        // Auto-reload takes precedence over commands so DONE lasts exactly one cycle.
        if (reload) begin
          clr_cnt = 1'b1;
          state_d = RUN;
        end else if (cmd_clear) begin
          clr_cnt = 1'b1;
          state_d = IDLE;
        end else if (cmd_start) begin
          clr_cnt = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        clr_cnt = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    running = (state_q == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      done_q <= done_d;
      wrap_q <= wrap_d;
      terr_q <= terr_d;
    end
  end

  assign done       = done_q;
  assign wrap       = wrap_q;
  assign target_err = terr_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed self-checking bench for bcd_timer_ctrl with DIGITS = 4.
module tb_bcd_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start, cmd_stop, cmd_clear, tick, reload;
  logic [15:0] target;
  logic [15:0] count;
  logic        running, done, wrap, target_err;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  bcd_timer_ctrl #(.DIGITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_start  (cmd_start),
    .cmd_stop   (cmd_stop),
    .cmd_clear  (cmd_clear),
    .tick       (tick),
    .reload     (reload),
    .target     (target),
    .count      (count),
    .running    (running),
    .done       (done),
    .wrap       (wrap),
    .target_err (target_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0;
    tick = 1'b0; reload = 1'b0; target = 16'h0005;
    #12;
    chk16("rst_count", count, 16'h0000);
    chk1("rst_running", running, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_wrap", wrap, 1'b0);
    chk1("rst_terr", target_err, 1'b0);
    rst = 1'b0;
    step();
    chk1("idle_running", running, 1'b0);

    // Start, five ticks to target 0005
    cmd_start = 1'b1; step(); cmd_start = 1'b0;
    chk1("start_running", running, 1'b1);
    chk16("start_count", count, 16'h0000);
    ticks(4);
    chk16("t4_count", count, 16'h0004);
    chk1("t4_done", done, 1'b0);
    ticks(1);
    chk16("t5_count", count, 16'h0005);
    chk1("t5_done", done, 1'b1);
    chk1("t5_running", running, 1'b0);
    step();
    chk1("t5_done_pulse", done, 1'b0);
    chk16("done_hold_count", count, 16'h0005);
    chk1("done_hold_running", running, 1'b0);

    // Multi-digit carry toward 0150
    target = 16'h0150;
    cmd_start = 1'b1; step(); cmd_start = 1'b0;
    chk16("restart_count", count, 16'h0000);
    chk1("restart_running", running, 1'b1);
    ticks(99);
    chk16("c99_count", count, 16'h0099);
    ticks(1);
    chk16("c100_count", count, 16'h0100);
    chk1("c100_done", done, 1'b0);
    ticks(49);
    chk16("c149_count", count, 16'h0149);
    chk1("c149_done", done, 1'b0);
    ticks(1);
    chk16("c150_count", count, 16'h0150);
    chk1("c150_done", done, 1'b1);

    // All-9s wrap with target 0000: done and wrap together
    target = 16'h0000;
    cmd_start = 1'b1; step(); cmd_start = 1'b0;
    chk16("w_start_count", count, 16'h0000);
    chk1("w_start_done", done, 1'b0);
    ticks(9999);
    chk16("w9999_count", count, 16'h9999);
    chk1("w9999_wrap", wrap, 1'b0);
    chk1("w9999_running", running, 1'b1);
    ticks(1);
    chk16("wrap_count", count, 16'h0000);
    chk1("wrap_done", done, 1'b1);
    chk1("wrap_wrap", wrap, 1'b1);
    chk1("wrap_running", running, 1'b0);
    step();
    chk1("wrap_done_pulse", done, 1'b0);
    chk1("wrap_wrap_pulse", wrap, 1'b0);

    // Stop with tick: tick discarded, pause, resume
    target = 16'h0020;
    cmd_start = 1'b1; step(); cmd_start = 1'b0;
    ticks(3);
    chk16("s3_count", count, 16'h0003);
    cmd_stop = 1'b1; tick = 1'b1; step(); cmd_stop = 1'b0; tick = 1'b0;
    chk16("stop_count", count, 16'h0003);
    chk1("stop_running", running, 1'b0);
    ticks(2);
    chk16("pause_tick_count", count, 16'h0003);
    cmd_start = 1'b1; step(); cmd_start = 1'b0;
    chk1("resume_running", running, 1'b1);
    chk16("resume_count", count, 16'h0003);
    ticks(2);
    chk16("resume_t2_count", count, 16'h0005);

    // All commands and tick together: clear wins
    cmd_clear = 1'b1; cmd_stop = 1'b1; cmd_start = 1'b1; tick = 1'b1;
    step();
    cmd_clear = 1'b0; cmd_stop = 1'b0; cmd_start = 1'b0; tick = 1'b0;
    chk16("allcmd_count", count, 16'h0000);
    chk1("allcmd_running", running, 1'b0);
    chk1("allcmd_done", done, 1'b0);

    // Invalid target: flagged, never matches through a full wrap
    target = 16'h00A3;
    step();
    chk1("terr_set", target_err, 1'b1);
    cmd_start = 1'b1; step(); cmd_start = 1'b0;
    ticks(10000);
    chk16("terr_wrap_count", count, 16'h0000);
    chk1("terr_wrap_wrap", wrap, 1'b1);
    chk1("terr_wrap_done", done, 1'b0);
    chk1("terr_wrap_running", running, 1'b1);
    step();
    chk1("terr_wrap_pulse", wrap, 1'b0);

    // Auto-reload with target 0002
    cmd_clear = 1'b1; step(); cmd_clear = 1'b0;
    chk16("clr_count", count, 16'h0000);
    target = 16'h0002; reload = 1'b1;
    cmd_start = 1'b1; step(); cmd_start = 1'b0;
    chk1("terr_clear", target_err, 1'b0);
    tick = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk16("reload_count", count, ((i % 3) == 2) ? 16'h0000 : 16'((i % 3) + 1));
      chk1("reload_done", done, (i % 3) == 1);
      chk1("reload_running", running, (i % 3) != 1);
    end
    tick = 1'b0; reload = 1'b0;
    step();
    chk16("reload_off_hold", count, 16'h0002);
    chk1("reload_off_running", running, 1'b0);

    // Asynchronous reset mid-count
    target = 16'h00A3;
    cmd_start = 1'b1; step(); cmd_start = 1'b0;
    ticks(7);
    chk16("pre_rst_count", count, 16'h0007);
    chk1("pre_rst_terr", target_err, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk16("arst_count", count, 16'h0000);
    chk1("arst_running", running, 1'b0);
    chk1("arst_done", done, 1'b0);
    chk1("arst_wrap", wrap, 1'b0);
    chk1("arst_terr", target_err, 1'b0);
    #1 rst = 1'b0;
    target = 16'h0003;
    step();
    chk1("post_rst_running", running, 1'b0);
    chk16("post_rst_count", count, 16'h0000);
    cmd_start = 1'b1; step(); cmd_start = 1'b0;
    chk1("post_rst_start", running, 1'b1);
    ticks(3);
    chk1("post_rst_done", done, 1'b1);
    chk16("post_rst_t3", count, 16'h0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
